// File: rtl/bin2bcd_display_feed_if.sv
// Input handshake and display-side result bundle for the binary-to-BCD feed.
// The master drives values in; the slave converts them and drives the results out.
interface bin2bcd_display_feed_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
);
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_o;
  logic [DIGITS-1:0]   blank_o;
  logic                done_o;

  modport master (
    output in_data, in_valid,
    input  in_ready, bcd_o, blank_o, done_o
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, bcd_o, blank_o, done_o
  );
endinterface

// File: rtl/bin2bcd_display_feed.sv
// Sequential double-dabble converter feeding a multiplexed 7-segment scanner.
// bcd_o/blank_o are held between conversions and only change on LATCH or reset.
module bin2bcd_display_feed #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input logic                   clk,
  input logic                   rst,
  bin2bcd_display_feed_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] corr;
  logic [DIGITS-1:0]   blank_calc;
  logic                upper_zero;

  // Add-3 correction on every digit >= 5; the result stays within 4 bits.
  always_comb begin
    corr = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Blank a digit when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    blank_calc    = '0;
    upper_zero    = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (scratch_q[4*i +: 4] == 4'd0);
      blank_calc[i] = upper_zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          bin_d     = bus.in_data;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, bin_d} = {corr, bin_q} << 1;
        cnt_d              = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        bcd_d   = scratch_q;
        blank_d = blank_calc;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = (state_q == StIdle);
  assign bus.bcd_o    = bcd_q;
  assign bus.blank_o  = blank_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// Directed bench for bin2bcd_display_feed: reset, conversions, back-to-back,
// busy-input rejection and mid-conversion reset, with hand-computed expectations.
module tb_bin2bcd_display_feed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   done_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  logic [39:0] last_bcd = '0;

  bin2bcd_display_feed_if #(.WIDTH(32), .DIGITS(10)) bus ();

  bin2bcd_display_feed #(.WIDTH(32), .DIGITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for done_o (bounded); flags in_ready high or bcd_o moving before done.
  task automatic wait_done(input logic [39:0] hold, output int t, output bit rdy_bad,
                           output bit hold_bad);
    t        = -1;
    rdy_bad  = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        t = cyc;
        break;
      end
      if (bus.in_ready) rdy_bad = 1'b1;
      if (bus.bcd_o !== hold) hold_bad = 1'b1;
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic [39:0] exp_bcd,
                         input logic [9:0] exp_blank);
    int t0, t;
    bit rb, hb;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    t0 = cyc;
    chk({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    wait_done(last_bcd, t, rb, hb);
    chk({tag, "_latency"}, 64'(t - t0), 64'd33);
    chk({tag, "_bcd"}, 64'(bus.bcd_o), 64'(exp_bcd));
    chk({tag, "_blank"}, 64'(bus.blank_o), 64'(exp_blank));
    chk({tag, "_ready_at_done"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_ready_low_while_busy"}, 64'(rb), 64'd0);
    chk({tag, "_bcd_held"}, 64'(hb), 64'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(bus.done_o), 64'd0);
    last_bcd = exp_bcd;
  endtask

  initial begin
    int t0, t1, t2, dc;
    bit rb, hb;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_bcd", 64'(bus.bcd_o), 64'd0);
    chk("reset_blank", 64'(bus.blank_o), 64'h3FE);
    chk("reset_done", 64'(bus.done_o), 64'd0);
    chk("reset_ready", 64'(bus.in_ready), 64'd1);

    convert("c1234567890", 32'h499602D2, 40'h1234567890, 10'h000);
    convert("cmax", 32'hFFFFFFFF, 40'h4294967295, 10'h000);
    convert("c7", 32'd7, 40'h0000000007, 10'h3FE);
    convert("c1000", 32'd1000, 40'h0000001000, 10'h3F0);
    convert("c0", 32'd0, 40'h0000000000, 10'h3FE);

    // Back-to-back with in_valid held high
    dc = done_cnt;
    bus.in_data  = 32'd42;
    bus.in_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.in_data = 32'd99;
    wait_done(last_bcd, t1, rb, hb);
    chk("b2b_first_latency", 64'(t1 - t0), 64'd33);
    chk("b2b_first_bcd", 64'(bus.bcd_o), 64'h42);
    chk("b2b_first_blank", 64'(bus.blank_o), 64'h3FC);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_second_accepted", 64'(bus.in_ready), 64'd0);
    wait_done(40'h42, t2, rb, hb);
    chk("b2b_spacing", 64'(t2 - t1), 64'd34);
    chk("b2b_hold_42", 64'(hb), 64'd0);
    chk("b2b_second_bcd", 64'(bus.bcd_o), 64'h99);
    chk("b2b_second_blank", 64'(bus.blank_o), 64'h3FC);
    repeat (40) @(negedge clk);
    chk("b2b_done_count", 64'(done_cnt - dc), 64'd2);
    last_bcd = 40'h99;

    // Input changes while busy must be ignored
    dc = done_cnt;
    bus.in_data  = 32'd5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.in_data = 32'd8;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
    end
    bus.in_valid = 1'b0;
    wait_done(last_bcd, t1, rb, hb);
    chk("busy_latency", 64'(t1 - t0), 64'd33);
    chk("busy_bcd", 64'(bus.bcd_o), 64'd5);
    chk("busy_blank", 64'(bus.blank_o), 64'h3FE);
    repeat (40) @(negedge clk);
    chk("busy_done_count", 64'(done_cnt - dc), 64'd1);
    last_bcd = 40'd5;

    // Reset during SHIFT aborts the conversion
    dc = done_cnt;
    bus.in_data  = 32'd123456;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_bcd", 64'(bus.bcd_o), 64'd0);
    chk("midrst_blank", 64'(bus.blank_o), 64'h3FE);
    chk("midrst_done", 64'(bus.done_o), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - dc), 64'd0);
    last_bcd = '0;
    convert("c9_after_reset", 32'd9, 40'h0000000009, 10'h3FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
